// File: rtl/awgn_chan.sv
// awgn_chan: BPSK maps a bit to +/-1.0 in Q5,11 and adds LFSR/CLT Gaussian noise scaled by snr_idx.
// Noise path is built only when AWGN_CHAN_NOISE_EN is defined; otherwise the sample is exactly +/-2048.
module awgn_chan #(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  input  logic [3:0]  snr_idx,
  output logic [15:0] sample,
  output logic        sample_valid,
  input  logic        sample_ready
);
  typedef enum logic [1:0] {IDLE, GEN, MUL, OUT} state_t;
  state_t state, nxt;
  logic bit_q;
  logic [15:0] map, result;
  assign bit_ready = state == IDLE;
  assign sample_valid = state == OUT;
  assign map = bit_q ? 16'hf800 : 16'h0800;
`ifdef AWGN_CHAN_NOISE_EN
  localparam state_t START = GEN;
  localparam logic [31:0] LFSR_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [10:0] SIGMA [16] = '{
    11'd791, 11'd773, 11'd755, 11'd738, 11'd721, 11'd704, 11'd688, 11'd673,
    11'd657, 11'd643, 11'd628, 11'd628, 11'd628, 11'd628, 11'd628, 11'd628};
  logic [31:0] lfsr;
  logic [13:0] acc;
  logic [1:0] cnt;
  logic [3:0] snr_q;
  logic signed [14:0] g;
  logic signed [26:0] prod;
  // Sum of four 12-bit uniforms is centred on 8190; the arithmetic shift floors toward -inf.
  assign g = $signed({1'b0, acc}) - 15'sd8190;
  assign prod = g * $signed({1'b0, SIGMA[snr_q]});
  assign result = map + 16'(prod >>> 11);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lfsr <= LFSR_INIT;
      acc <= '0;
      cnt <= '0;
      snr_q <= '0;
    end else if (state == IDLE && bit_valid) begin
      acc <= '0;
      cnt <= '0;
      snr_q <= snr_idx;
    end else if (state == GEN) begin
      acc <= acc + {2'b00, lfsr[11:0]};
      lfsr <= lfsr[0] ? (lfsr >> 1) ^ 32'h8020_0003 : lfsr >> 1;
      cnt <= cnt + 2'd1;
    end
`else
  localparam state_t START = MUL;
  logic unused_cfg;
  assign unused_cfg = ^{snr_idx, SEED};
  assign result = map;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = bit_valid ? START : IDLE;
`ifdef AWGN_CHAN_NOISE_EN
      GEN: nxt = (cnt == 2'd3) ? MUL : GEN;
`endif
      MUL: nxt = OUT;
      OUT: nxt = sample_ready ? IDLE : OUT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bit_q <= 1'b0;
      sample <= '0;
    end else begin
      if (state == IDLE && bit_valid) bit_q <= bit_in;
      if (state == MUL) sample <= result;
    end
endmodule

// File: tb/tb_awgn_chan.sv
// tb_awgn_chan: randomized bench for awgn_chan against an arithmetic golden model of the noise channel.
module tb_awgn_chan;
`ifdef AWGN_CHAN_NOISE_EN
  localparam bit NOISE = 1'b1;
  localparam int LAT = 5;
`else
  localparam bit NOISE = 1'b0;
  localparam int LAT = 1;
`endif
  localparam logic [31:0] SEED = 32'h0000_0001;
  logic clk = 1'b0, rst = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, sample_ready = 1'b0;
  logic [3:0] snr_idx = 4'd0;
  logic bit_ready, sample_valid;
  logic [15:0] sample;
  int checks = 0, failures = 0;
  logic [31:0] m_lfsr = SEED;
  int sig_tab[11] = '{791, 773, 755, 738, 721, 704, 688, 673, 657, 643, 628};

  awgn_chan #(.SEED(SEED)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .snr_idx(snr_idx), .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Golden channel: four LFSR draws summed, centred, scaled by sigma/2048 with floor, added to BPSK level.
  task automatic model(input bit b, input logic [3:0] s, output int exp);
    int acc, p, n;
    exp = b ? -2048 : 2048;
    if (NOISE) begin
      acc = 0;
      for (int i = 0; i < 4; i++) begin
        acc += int'(m_lfsr[11:0]);
        m_lfsr = m_lfsr[0] ? (m_lfsr >> 1) ^ 32'h8020_0003 : m_lfsr >> 1;
      end
      p = (acc - 8190) * sig_tab[(s > 4'd10) ? 10 : int'(s)];
      n = (p >= 0) ? p / 2048 : -((-p + 2047) / 2048);
      exp += n;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (sample_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic accept(input bit b, input logic [3:0] s, input logic [3:0] s_late);
    @(negedge clk);
    chk("bit_ready_idle", bit_ready, 1);
    bit_in = b;
    snr_idx = s;
    bit_valid = 1'b1;
    @(posedge clk);
    #1 bit_valid = 1'b0;
    bit_in = ~b;
    snr_idx = s_late;
    chk("valid_low_after_accept", sample_valid, 0);
  endtask

  task automatic send(input bit b, input logic [3:0] s, input logic [3:0] s_late);
    int lat, exp, got;
    accept(b, s, s_late);
    wait_valid(lat);
    chk("latency", lat, LAT);
    model(b, s, exp);
    got = int'($signed(sample));
    chk("sample", got, exp);
    chk("bound", (got <= 6139 && got >= -6139) ? 1 : 0, 1);
    sample_ready = 1'b1;
    @(posedge clk);
    #1 sample_ready = 1'b0;
    chk("valid_drop", sample_valid, 0);
  endtask

  initial begin
    int lat, exp;
    logic [15:0] held;
    #12;
    chk("rst_bit_ready", bit_ready, 1);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_sample", sample, 0);
    @(negedge clk);
    rst = 1'b0;
    sample_ready = 1'b1;
    @(posedge clk);
    #1 chk("ready_no_valid", bit_ready, 1);
    sample_ready = 1'b0;
    send(1'b0, 4'd0, 4'd0);
    send(1'b1, 4'd0, 4'd0);
    send(1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 64; i++) send(1'($urandom_range(0, 1)), 4'd0, 4'($urandom_range(0, 15)));
    send(1'b0, 4'd0, 4'd9);
    send(1'b1, 4'd0, 4'd9);
    for (int i = 0; i < 24; i++) send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'd0);
    // backpressure with an ignored bit_valid pulse mid-stall
    @(negedge clk);
    bit_in = 1'b1;
    snr_idx = 4'd3;
    bit_valid = 1'b1;
    @(posedge clk);
    #1 bit_valid = 1'b0;
    wait_valid(lat);
    chk("stall_latency", lat, LAT);
    held = sample;
    model(1'b1, 4'd3, exp);
    chk("stall_sample", int'($signed(held)), exp);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        bit_valid = 1'b1;
        bit_in = 1'b0;
      end
      @(posedge clk);
      #1 bit_valid = 1'b0;
      chk("stall_hold", sample, held);
      chk("stall_valid", sample_valid, 1);
      chk("stall_bit_ready", bit_ready, 0);
    end
    sample_ready = 1'b1;
    @(posedge clk);
    #1 sample_ready = 1'b0;
    send(1'b0, 4'd5, 4'd5);
    // reset during generation
    accept(1'b1, 4'd0, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_gen_valid", sample_valid, 0);
    chk("rst_gen_ready", bit_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = SEED;
    send(1'b0, 4'd0, 4'd0);
    // reset while holding an output
    accept(1'b1, 4'd2, 4'd2);
    wait_valid(lat);
    chk("out_valid_pre", sample_valid, 1);
    #2 rst = 1'b1;
    #1 chk("rst_out_valid", sample_valid, 0);
    chk("rst_out_ready", bit_ready, 1);
    chk("rst_out_sample", sample, 0);
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = SEED;
    send(1'b1, 4'd0, 4'd0);
    for (int i = 0; i < 150; i++) send(1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 150; i++) send(1'b0, 4'd10, 4'd10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
